// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//
// Purpose:
//   This controller handles one CPU access at a time for the cache array.
//   For each access it latches the request and does the tag lookup.
//   - A read hit completes at once.
//   - A read miss refills the whole block from RAM, one word per beat, in
//     ascending order. The cache validates the block only on fill_last.
//   - A write goes through to RAM and never allocates. The cached copy is
//     updated only when the lookup hit.
//   The block also keeps saturating hit and miss counters.
//
// Ports:
//   clk, reset_n       clock (rising edge) and async active-low reset
//   request            CPU access request, sampled only in IDLE
//   address            CPU word address
//   write_data         CPU store data
//   write_en           1 = store, 0 = load
//   busy               high in every state except IDLE
//   done               one-cycle completion pulse
//   lookup_address     latched access address presented to the cache
//   hit                cache tag match for lookup_address (combinational)
//   fill_en            write one word into the cache this cycle
//   fill_address       word address for fill_en
//   fill_data          word for fill_en
//   fill_last          final word of a block refill
//   mem_req            RAM request, held until mem_ack
//   mem_address        RAM word address
//   mem_write_en       RAM store
//   mem_write_data     RAM store data
//   mem_ack            RAM beat complete, read data valid in the same cycle
//   mem_read_data      RAM load data
//   hit_count          saturating hit counter
//   miss_count         saturating miss counter
//   state_dbg          current FSM state, for checkers and debug
//
// RAM handshake: mem_req acts as "valid" and mem_ack acts as "ready".
// A beat transfers in the cycle where both are high. While mem_ack is low,
// mem_req, mem_address, mem_write_en and mem_write_data hold their values.
// mem_ack is ignored whenever mem_req is low.
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_WIDTH       = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    // CPU side
    input  logic                        request,
    input  logic [RAM_ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]       write_data,
    input  logic                        write_en,
    output logic                        busy,
    output logic                        done,
    // cache lookup port
    output logic [RAM_ADDRESS_BITS-1:0] lookup_address,
    input  logic                        hit,
    // cache fill port
    output logic                        fill_en,
    output logic [RAM_ADDRESS_BITS-1:0] fill_address,
    output logic [DATA_WIDTH-1:0]       fill_data,
    output logic                        fill_last,
    // RAM port
    output logic                        mem_req,
    output logic [RAM_ADDRESS_BITS-1:0] mem_address,
    output logic                        mem_write_en,
    output logic [DATA_WIDTH-1:0]       mem_write_data,
    input  logic                        mem_ack,
    input  logic [DATA_WIDTH-1:0]       mem_read_data,
    // performance counters
    output logic [COUNT_WIDTH-1:0]      hit_count,
    output logic [COUNT_WIDTH-1:0]      miss_count,
    // debug
    output logic [2:0]                  state_dbg
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_REFILL = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [BLOCK_BITS-1:0]  LAST_BEAT = '1;
    localparam logic [BLOCK_BITS-1:0]  BEAT_ONE  = BLOCK_BITS'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]                  state_q;
    logic [2:0]                  state_d;
    logic [RAM_ADDRESS_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic                        we_q;
    logic                        wr_hit_q;
    logic [BLOCK_BITS-1:0]       beat_q;
    logic [COUNT_WIDTH-1:0]      hit_count_q;
    logic [COUNT_WIDTH-1:0]      miss_count_q;

    // -------------------------------------------------------------------------
    // State decodes
    // -------------------------------------------------------------------------
    logic in_idle;
    logic in_lookup;
    logic in_refill;
    logic in_write;
    logic in_done;
    logic refill_beat;   // a refill word arrives this cycle
    logic write_beat;    // the write-through store completes this cycle
    logic refill_final;  // the arriving refill word is the last of the block

    // Refill address: block-aligned base from the latched address, with the
    // beat counter in the low bits.
    logic [RAM_ADDRESS_BITS-1:0] refill_address;

    assign in_idle   = (state_q == S_IDLE);
    assign in_lookup = (state_q == S_LOOKUP);
    assign in_refill = (state_q == S_REFILL);
    assign in_write  = (state_q == S_WRITE);
    assign in_done   = (state_q == S_DONE);

    assign refill_beat  = in_refill && mem_ack;
    assign write_beat   = in_write && mem_ack;
    assign refill_final = refill_beat && (beat_q == LAST_BEAT);

    assign refill_address = {addr_q[RAM_ADDRESS_BITS-1:BLOCK_BITS], beat_q};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (request) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // Writes always go to RAM. Reads go to RAM only on a miss.
                if (we_q) begin
                    state_d = S_WRITE;
                end else if (hit) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (refill_final) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // request is deliberately not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Access latch: captured once per access, when the request is accepted
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (in_idle && request) begin
            addr_q  <= address;
            wdata_q <= write_data;
            we_q    <= write_en;
        end
    end

    // -------------------------------------------------------------------------
    // Lookup result for writes. It is held through the RAM store because the
    // cache's hit output is only valid while the lookup is in progress.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_hit_q <= 1'b0;
        end else if (in_lookup) begin
            wr_hit_q <= hit;
        end
    end

    // -------------------------------------------------------------------------
    // Refill beat counter. It is cleared on the way into a refill, so an
    // aborted refill always restarts at word 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else if (in_lookup) begin
            beat_q <= '0;
        end else if (refill_beat) begin
            beat_q <= beat_q + BEAT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters. Each access is classified once, in
    // LOOKUP: writes are counted by their lookup result just like reads.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (in_lookup) begin
            if (hit) begin
                if (hit_count_q != COUNT_MAX) begin
                    hit_count_q <= hit_count_q + COUNT_ONE;
                end
            end else begin
                if (miss_count_q != COUNT_MAX) begin
                    miss_count_q <= miss_count_q + COUNT_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy           = !in_idle;
    assign done           = in_done;
    assign lookup_address = addr_q;

    assign mem_req        = in_refill || in_write;
    assign mem_write_en   = in_write;
    assign mem_address    = in_refill ? refill_address : addr_q;
    assign mem_write_data = wdata_q;

    // Refill words pass straight from RAM into the cache in the ack cycle.
    // Write-through updates the cached copy only when the lookup hit.
    assign fill_en        = refill_beat || (write_beat && wr_hit_q);
    assign fill_address   = in_refill ? refill_address : addr_q;
    assign fill_data      = in_refill ? mem_read_data : wdata_q;
    assign fill_last      = refill_final;

    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Self-checking bench for cache_refill_ctrl. COUNT_WIDTH is 4, so counter
// saturation can be reached quickly.
//
// A transaction-level model predicts, for every access:
//   - the RAM beats (address, direction, store data) in order;
//   - the cache fill words (address, data, last flag) in order;
//   - the done latency from the lookup plus observed RAM wait cycles;
//   - the saturating hit and miss counts.
// One compare process checks the DUT against these predictions every cycle.
// Directed tests pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BB = 2;
    localparam int CW = 4;
    localparam int NB = 4;
    localparam int CMAX = 15;

    // -------------------------------------------------------------------------
    // Clock and reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUT signals
    // -------------------------------------------------------------------------
    logic          request = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] write_data = '0;
    logic          write_en = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] lookup_address;
    logic          hit = 1'b0;
    logic          fill_en;
    logic [AW-1:0] fill_address;
    logic [DW-1:0] fill_data;
    logic          fill_last;
    logic          mem_req;
    logic [AW-1:0] mem_address;
    logic          mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_read_data = '0;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    logic [2:0]    state_dbg;

    cache_refill_ctrl #(
        .RAM_ADDRESS_BITS (AW),
        .DATA_WIDTH       (DW),
        .BLOCK_BITS       (BB),
        .COUNT_WIDTH      (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .request        (request),
        .address        (address),
        .write_data     (write_data),
        .write_en       (write_en),
        .busy           (busy),
        .done           (done),
        .lookup_address (lookup_address),
        .hit            (hit),
        .fill_en        (fill_en),
        .fill_address   (fill_address),
        .fill_data      (fill_data),
        .fill_last      (fill_last),
        .mem_req        (mem_req),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .state_dbg      (state_dbg)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    //   queue entry layout: {flag, address[AW-1:0], data[DW-1:0]}
    //   mem entries:  flag = write enable
    //   fill entries: flag = last word of block
    // -------------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;
    logic [42:0] exp_mem_q[$];
    logic [42:0] exp_fill_q[$];
    logic [42:0] fill_log[$];
    logic [42:0] cmp_e;
    logic [DW-1:0] ram [0:1023];
    logic [AW-1:0] cur_addr = '0;
    int exp_hits = 0;
    int exp_misses = 0;
    int req_cycles = 0;
    int total_waits = 0;
    int last_seen = 0;
    int wait_lo = 0;
    int wait_hi = 0;
    int wait_left = 0;
    bit chk_en = 1'b0;
    bit resp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // -------------------------------------------------------------------------
    // RAM responder. It drives just after the rising edge and acks each beat
    // after a random number of wait cycles. Outside a request, it toggles
    // mem_ack randomly; the DUT must ignore those acks.
    // -------------------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        if (resp_en) begin
            if (mem_req) begin
                if (wait_left > 0) begin
                    mem_ack = 1'b0;
                    mem_read_data = $urandom;
                    wait_left--;
                    total_waits++;
                end else begin
                    mem_ack = 1'b1;
                    mem_read_data = ram[mem_address];
                    wait_left = $urandom_range(wait_hi, wait_lo);
                end
            end else begin
                mem_ack = 1'($urandom_range(1, 0));
                mem_read_data = $urandom;
                wait_left = $urandom_range(wait_hi, wait_lo);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare process: on every falling edge, check invariants and consume
    // the predicted RAM beats and fill words.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (!busy) begin
                check("idle_mem_req", mem_req, 0);
                check("idle_fill_en", fill_en, 0);
                check("idle_done", done, 0);
            end else begin
                check("lookup_address", lookup_address, cur_addr);
            end
            if (done) begin
                check("done_mem_req", mem_req, 0);
                check("done_fill_en", fill_en, 0);
            end
            if (fill_en) begin
                if (fill_last) last_seen++;
                fill_log.push_back({fill_last, fill_address, fill_data});
                if (exp_fill_q.size() == 0) begin
                    report("unexpected_fill", {fill_address, fill_data}, 0);
                end else begin
                    cmp_e = exp_fill_q.pop_front();
                    check("fill_address", fill_address, cmp_e[41:32]);
                    check("fill_data", fill_data, cmp_e[31:0]);
                    check("fill_last", fill_last, cmp_e[42]);
                end
            end else begin
                check("fill_last_without_fill", fill_last, 0);
            end
            if (mem_req) begin
                req_cycles++;
                if (exp_mem_q.size() == 0) begin
                    report("unexpected_mem_req", mem_address, 0);
                end else begin
                    cmp_e = exp_mem_q[0];
                    check("mem_address", mem_address, cmp_e[41:32]);
                    check("mem_write_en", mem_write_en, cmp_e[42]);
                    if (cmp_e[42]) check("mem_write_data", mem_write_data, cmp_e[31:0]);
                    if (mem_ack) void'(exp_mem_q.pop_front());
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks. Each is called from a falling edge with the DUT idle.
    // -------------------------------------------------------------------------
    task automatic start_access(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic we, input logic h);
        logic [AW-1:0] base;
        logic [AW-1:0] wa;
        base = {a[AW-1:BB], 2'b00};
        if (we) begin
            exp_mem_q.push_back({1'b1, a, wd});
            if (h) exp_fill_q.push_back({1'b0, a, wd});
        end else if (!h) begin
            for (int b = 0; b < NB; b++) begin
                wa = base + AW'(b);
                exp_mem_q.push_back({1'b0, wa, 32'h0});
                exp_fill_q.push_back({(b == NB - 1), wa, ram[wa]});
            end
        end
        if (h) exp_hits = (exp_hits < CMAX) ? exp_hits + 1 : CMAX;
        else   exp_misses = (exp_misses < CMAX) ? exp_misses + 1 : CMAX;
        cur_addr    = a;
        address     = a;
        write_data  = wd;
        write_en    = we;
        hit         = h;
        request     = 1'b1;
        req_cycles  = 0;
        total_waits = 0;
        @(posedge clk);
    endtask

    task automatic finish_access(input logic we, input logic h, input bit hold_req,
                                 output int lat);
        int exp_lat;
        int exp_req;
        @(negedge clk);
        request = 1'b0;
        lat = 1;
        check("busy_after_sample", busy, 1);
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            // Once the lookup is over, the cache's hit output means nothing.
            if (lat == 2) hit = 1'($urandom_range(1, 0));
        end
        if (!done) begin
            report("done_timeout", lat, 0);
            exp_mem_q.delete();
            exp_fill_q.delete();
        end else begin
            exp_req = (we ? 1 : (h ? 0 : NB)) + total_waits;
            exp_lat = (we ? 3 : (h ? 2 : 2 + NB)) + total_waits;
            check("latency", lat, exp_lat);
            check("req_cycles", req_cycles, exp_req);
            check("fill_q_drained", exp_fill_q.size(), 0);
            check("mem_q_drained", exp_mem_q.size(), 0);
            check("hit_count", hit_count, exp_hits);
            check("miss_count", miss_count, exp_misses);
        end
        if (hold_req) request = 1'b1;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        request = 1'b0;
    endtask

    task automatic do_access(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic we, input logic h, input bit hold_req,
                             output int lat);
        start_access(a, wd, we, h);
        finish_access(we, h, hold_req, lat);
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int lat;
        int g;
        logic [AW-1:0] ra;
        logic wr;
        logic hv;

        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        for (int i = 0; i < NB; i++) ram[10'h2C + i] = 32'hA0 + i;

        // Reset asserted while request and mem_ack are both high.
        reset_n = 1'b0;
        request = 1'b1;
        mem_ack = 1'b1;
        address = 10'h2D;
        write_data = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fill_en", fill_en, 0);
        check("rst_fill_last", fill_last, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_write_en", mem_write_en, 0);
        check("rst_lookup_address", lookup_address, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_write_data", mem_write_data, 0);
        check("rst_fill_data", fill_data, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        mem_ack = 1'b0;
        resp_en = 1'b1;
        chk_en = 1'b1;
        reset_n = 1'b1;

        // Read miss at 0x2D with back-to-back acks.
        fill_log.delete();
        do_access(10'h2D, 32'h0, 1'b0, 1'b0, 1'b0, lat);
        check("miss_latency_lit", lat, 6);
        check("miss_count_lit", miss_count, 1);
        check("miss_fill_words", fill_log.size(), 4);
        if (fill_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("miss_fill_addr_lit", fill_log[i][41:32], 10'h2C + i);
                check("miss_fill_data_lit", fill_log[i][31:0], 32'hA0 + i);
                check("miss_fill_last_lit", fill_log[i][42], (i == 3));
            end
        end

        // Read hit at 0x2D. request is raised during done and must be ignored.
        do_access(10'h2D, 32'h0, 1'b0, 1'b1, 1'b1, lat);
        check("hit_latency_lit", lat, 2);
        check("hit_count_lit", hit_count, 1);
        check("hit_no_mem_req", req_cycles, 0);

        // Write hit at 0x13 with a 3-cycle RAM delay.
        wait_lo = 3;
        wait_hi = 3;
        fill_log.delete();
        do_access(10'h13, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, lat);
        check("wr_hit_req_cycles_lit", req_cycles, 4);
        check("wr_hit_latency_lit", lat, 6);
        check("wr_hit_fills", fill_log.size(), 1);
        if (fill_log.size() == 1) begin
            check("wr_hit_fill_lit", fill_log[0], {1'b0, 10'h13, 32'hDEADBEEF});
        end

        // Write miss: RAM store only, the cache is untouched.
        fill_log.delete();
        do_access(10'h13, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, lat);
        check("wr_miss_no_fill", fill_log.size(), 0);
        check("wr_miss_latency_lit", lat, 6);

        // Reset during beat 2 of a refill.
        wait_lo = 0;
        wait_hi = 0;
        fill_log.delete();
        last_seen = 0;
        start_access(10'h41, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        request = 1'b0;
        g = 0;
        while (fill_log.size() < 2 && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        @(negedge clk);
        check("abort_beat2_addr", mem_address, 10'h42);
        check("abort_beat2_req", mem_req, 1);
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_fill_en", fill_en, 0);
        check("abort_fill_last", fill_last, 0);
        check("abort_busy", busy, 0);
        check("abort_hit_count", hit_count, 0);
        check("abort_miss_count", miss_count, 0);
        check("abort_no_last", last_seen, 0);
        exp_mem_q.delete();
        exp_fill_q.delete();
        exp_hits = 0;
        exp_misses = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;
        fill_log.delete();
        do_access(10'h41, 32'h0, 1'b0, 1'b0, 1'b0, lat);
        check("restart_words", fill_log.size(), 4);
        if (fill_log.size() == 4) begin
            check("restart_beat0_lit", fill_log[0][41:32], 10'h40);
            check("restart_last_lit", fill_log[3][42], 1);
        end
        check("restart_miss_lit", miss_count, 1);

        // Hit counter saturation: 16 hits from zero must stop at 15.
        for (int i = 0; i < 16; i++) begin
            do_access(AW'($urandom_range(1023, 0)), 32'h0, 1'b0, 1'b1, 1'b0, lat);
        end
        check("hit_sat_lit", hit_count, 15);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            ra = AW'($urandom_range(1023, 0));
            wr = 1'($urandom_range(1, 0));
            hv = 1'($urandom_range(1, 0));
            wait_lo = 0;
            wait_hi = $urandom_range(3, 0);
            do_access(ra, $urandom, wr, hv, 1'($urandom_range(1, 0)), lat);
        end
        check("miss_sat_final", miss_count, exp_misses);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Sequencing controller for the direct/set-associative cache array: accepts one CPU access at a time, performs the tag lookup, and on a read miss fetches the whole block from RAM word by word into the cache. Writes are write-through, no-write-allocate. It sits between the CPU request port, the cache array (lookup and fill ports) and the RAM handshake port. It also keeps saturating hit and miss counters for performance monitoring.

## Interface
- RAM_ADDRESS_BITS, 10, word address width of RAM and CPU side
- DATA_WIDTH, 32, data word width
- BLOCK_BITS, 2, log2 of words per block (N = 2**BLOCK_BITS)
- COUNT_WIDTH, 16, width of each performance counter

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- request  in  1  CPU access request, sampled only in IDLE
- address  in  RAM_ADDRESS_BITS  CPU word address
- write_data  in  DATA_WIDTH  CPU store data
- write_en  in  1  1 = store, 0 = load
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: access complete (read data valid at cache output)
- lookup_address  out  RAM_ADDRESS_BITS  latched access address presented to cache
- hit  in  1  cache tag match for lookup_address (combinational from cache)
- fill_en  out  1  write one word into cache this cycle
- fill_address  out  RAM_ADDRESS_BITS  word address for fill_en
- fill_data  out  DATA_WIDTH  word for fill_en
- fill_last  out  1  marks final word of a block refill (cache sets tag/valid)
- mem_req  out  1  RAM request, held until mem_ack
- mem_address  out  RAM_ADDRESS_BITS  RAM word address
- mem_write_en  out  1  RAM store
- mem_write_data  out  DATA_WIDTH  RAM store data
- mem_ack  in  1  RAM beat complete; read data valid in same cycle
- mem_read_data  in  DATA_WIDTH  RAM load data
- hit_count, miss_count  out  COUNT_WIDTH  saturating counters

## Operation
- States: IDLE, LOOKUP, REFILL, WRITE, DONE.
- IDLE: on request=1, latch address/write_data/write_en and go to LOOKUP. Otherwise stay.
- LOOKUP (1 cycle): sample hit.
  - Read hit -> DONE; hit_count+1.
  - Read miss -> REFILL with beat counter = 0; miss_count+1.
  - Write -> WRITE; counts hit or miss by hit; latch hit as wr_hit.
- REFILL: mem_req=1, mem_write_en=0, mem_address = {latched address upper bits, beat counter}, block aligned, ascending order 0..N-1.
  - In each cycle with mem_ack=1, fill_en=1 combinationally, fill_address = mem_address and fill_data = mem_read_data; the counter then increments.
  - fill_last=1 on the ack of beat N-1, then -> DONE. mem_req stays high between beats.
- WRITE: mem_req=1, mem_write_en=1, mem_address/mem_write_data = latched values.
  - On mem_ack: if wr_hit, fill_en=1 with the latched address/data and fill_last=0; then -> DONE.
  - If not wr_hit, the cache is untouched.
- DONE: done=1 for exactly one cycle, then -> IDLE. request is not sampled in DONE.
- lookup_address always equals the latched address.
- Counters stop at 2**COUNT_WIDTH-1 and do not wrap.
- mem_ack outside REFILL/WRITE is ignored. fill_en and mem_req are never high in IDLE, LOOKUP or DONE.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE; busy, done, fill_en, fill_last, mem_req and mem_write_en = 0. Address/data registers, beat counter and both counters = 0.
- Reset mid-REFILL aborts the fill. No resume; the partial block is never marked valid because fill_last was not issued.
- Read hit: request sampled at edge E0; LOOKUP in cycle E0..E1; done high in cycle E1..E2. Next request is accepted at E2.
- Read miss with mem_ack every cycle: done is high N+2 cycles after E0 (LOOKUP, N REFILL cycles, DONE).
- Each RAM wait cycle (mem_req=1, mem_ack=0) adds exactly one cycle. Outputs stay stable while waiting.
- Write with mem_ack at first WRITE cycle: done 3 cycles after E0.
- Simultaneous request and done: the request is ignored. The CPU must hold request until busy=0 and the request is sampled.

## Test plan
- Reset with request=1 and mem_ack=1 -> all outputs 0. After release, the state enters LOOKUP one edge after request is sampled.
- Read 0x2D, hit=0, mem_ack every cycle, mem_read_data=0xA0+beat -> fill addresses 0x2C..0x2F with data 0xA0..0xA3; fill_last on 0x2F; done at E0+6; miss_count=1.
- Repeat read 0x2D with hit=1 -> no mem_req; done at E0+2; hit_count=1.
- Write 0x13 data 0xDEADBEEF with hit=1, mem_ack delayed 3 cycles -> mem_req/mem_write_en held 4 cycles; one fill_en at 0x13 with 0xDEADBEEF. Repeat with hit=0 -> no fill_en.
- Assert reset_n low during beat 2 of a refill -> mem_req and fill_en drop immediately; fill_last is never seen; the next read restarts from beat 0.
- Preload hit_count to max (COUNT_WIDTH=4, 15 hits), then one more hit -> hit_count stays 15.
